rx_os: RTL

Oversampling UART receiver, the receiving end of the existing `tx` serializer. Deserializes an 8N1-style frame (start bit, NBITS data bits LSB-first, one stop bit) from a serial line using the shared NTICK-per-bit baud tick. Delivers each good byte with a one-cycle strobe for the write side of the byte FIFO, and flags framing errors and break conditions.

---
 rtl/rx_os.sv | 139 +++++++++++++
 1 files changed

// File: rtl/rx_os.sv
// Oversampling UART receiver: start bit, NBITS data bits LSB-first, one stop bit.
// Samples each bit at its center using an NTICK-per-bit baud tick.
module rx_os #(
  parameter int unsigned NBITS = 8,
  parameter int unsigned NTICK = 16
) (
  input  logic             rx_clk,
  input  logic             rx_rst,
  input  logic             bdtick,
  input  logic             rx_ena,
  input  logic             rx_in,
  output logic [NBITS-1:0] data_out,
  output logic             rx_done,
  output logic             rx_ferr,
  output logic             rx_busy
);

  localparam int unsigned TW = $clog2(NTICK);
  localparam int unsigned BW = $clog2(NBITS + 1);
  localparam logic [TW-1:0] TMid  = TW'(NTICK / 2 - 1);
  localparam logic [TW-1:0] TLast = TW'(NTICK - 1);
  localparam logic [BW-1:0] BLast = BW'(NBITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [NBITS-1:0] sh_q, sh_d;
  logic [NBITS-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             rxs;

  assign rxs = sync2_q;

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rxs && rx_ena) begin
          state_d = StStart;
          tcnt_d  = '0;
        end
      end
      StStart: begin
        if (bdtick) begin
          if (tcnt_q == TMid) begin
            tcnt_d = '0;
            if (!rxs) begin
              state_d = StData;
              bcnt_d  = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      StData: begin
        if (bdtick) begin
          if (tcnt_q == TLast) begin
            // Right shift so the first data bit ends up in bit 0.
            sh_d            = sh_q >> 1;
            sh_d[NBITS-1]   = rxs;
            tcnt_d          = '0;
            bcnt_d          = bcnt_q + BW'(1);
            if (bcnt_q == BLast) begin
              state_d = StStop;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      StStop: begin
        if (bdtick) begin
          if (tcnt_q == TLast) begin
            tcnt_d = '0;
            if (rxs) begin
              data_d  = sh_q;
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              ferr_d  = 1'b1;
              state_d = StBreak;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      StBreak: begin
        if (rxs) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= StIdle;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_out = data_q;
  assign rx_done  = done_q;
  assign rx_ferr  = ferr_q;
  assign rx_busy  = (state_q != StIdle);

endmodule
